// File: rtl/tick_rate_gen_if.sv
// tick_rate_gen_if: raw/debounced switches and rate-tick outputs of the LED front-end.
// Rev 1.0
`default_nettype none

interface tick_rate_gen_if;
  logic [1:0] sw_in;
  logic [1:0] sw_db;
  logic [1:0] sw_rise;
  logic       tick;
  logic       sq;
  logic       rate_sel;

  modport master (output sw_in, input sw_db, input sw_rise, input tick, input sq, input rate_sel);
  modport slave  (input sw_in, output sw_db, output sw_rise, output tick, output sq, output rate_sel);
endinterface

`default_nettype wire

// File: rtl/tick_rate_gen.sv
// tick_rate_gen: switch synchroniser/debouncer plus boundary-safe fast/slow tick and square-wave generator.
// Rev 1.0
`default_nettype none

module tick_rate_gen #(
  parameter int DEB_CYC  = 1000000,
  parameter int FAST_DIV = 25000000,
  parameter int SLOW_DIV = 50000000
) (
  input  logic           clki,
  input  logic           rs,
  tick_rate_gen_if.slave bus
);

  localparam int MAX_DIV = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
  localparam int DW      = $clog2(DEB_CYC);
  localparam int PW      = $clog2(MAX_DIV);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
  localparam logic [PW-1:0] FAST_LAST = PW'(FAST_DIV - 1);
  localparam logic [PW-1:0] SLOW_LAST = PW'(SLOW_DIV - 1);

  logic [1:0]         meta;
  logic [1:0]         sync;
  logic [1:0]         db;
  logic [1:0]         db_nxt;
  logic [1:0]         rise;
  logic [1:0][DW-1:0] deb_cnt;
  logic [1:0][DW-1:0] deb_cnt_nxt;

  logic [PW-1:0]      pcnt;
  logic               wrap;
  logic               tick_q;
  logic               sq_q;
  logic               rate_q;

  always_ff @(posedge clki or posedge rs) begin
    if (rs) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= bus.sw_in;
      sync <= meta;
    end
  end

  // A bit flips only after sync has disagreed with it for DEB_CYC consecutive edges.
  always_comb begin
    db_nxt      = db;
    deb_cnt_nxt = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync[i] != db[i]) begin
        if (deb_cnt[i] == DEB_LAST) begin
          db_nxt[i] = ~db[i];
        end else begin
          deb_cnt_nxt[i] = deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clki or posedge rs) begin
    if (rs) begin
      db      <= '0;
      deb_cnt <= '0;
      rise    <= '0;
    end else begin
      db      <= db_nxt;
      deb_cnt <= deb_cnt_nxt;
      rise    <= db_nxt & ~db;
    end
  end

  assign wrap = (pcnt == (rate_q ? FAST_LAST : SLOW_LAST));

  // Rate is sampled from the registered debounced bit only at the wrap edge.
  always_ff @(posedge clki or posedge rs) begin
    if (rs) begin
      pcnt   <= '0;
      tick_q <= 1'b0;
      sq_q   <= 1'b0;
      rate_q <= 1'b0;
    end else begin
      tick_q <= wrap;
      if (wrap) begin
        pcnt   <= '0;
        sq_q   <= ~sq_q;
        rate_q <= db[1];
      end else begin
        pcnt <= pcnt + PW'(1);
      end
    end
  end

  assign bus.sw_db    = db;
  assign bus.sw_rise  = rise;
  assign bus.tick     = tick_q;
  assign bus.sq       = sq_q;
  assign bus.rate_sel = rate_q;

endmodule

`default_nettype wire

// File: tb/tb_tick_rate_gen.sv
// tb_tick_rate_gen: directed scenarios for tick_rate_gen with DEB_CYC=4, FAST_DIV=5, SLOW_DIV=10.
// Rev 1.0
`default_nettype none

module tb_tick_rate_gen;

  logic clk = 1'b0;
  logic rs  = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  tick_rate_gen_if bus ();

  tick_rate_gen #(
    .DEB_CYC (4),
    .FAST_DIV(5),
    .SLOW_DIV(10)
  ) dut (
    .clki(clk),
    .rs  (rs),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // Reset with the given switch value held; the first posedge after return is edge 1.
  task automatic release_reset(input logic [1:0] sw);
    rs         = 1'b1;
    bus.sw_in  = sw;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rs = 1'b0;
  endtask

  task automatic test_reset();
    bus.sw_in = 2'b11;
    #1;
    rs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (bus.sw_db    !== 2'b00) begin miscompares++; $display("FAIL reset_sw_db got %b want 00", bus.sw_db); end
    vectors++; if (bus.sw_rise  !== 2'b00) begin miscompares++; $display("FAIL reset_sw_rise got %b want 00", bus.sw_rise); end
    vectors++; if (bus.tick     !== 1'b0)  begin miscompares++; $display("FAIL reset_tick got %b want 0", bus.tick); end
    vectors++; if (bus.sq       !== 1'b0)  begin miscompares++; $display("FAIL reset_sq got %b want 0", bus.sq); end
    vectors++; if (bus.rate_sel !== 1'b0)  begin miscompares++; $display("FAIL reset_rate_sel got %b want 0", bus.rate_sel); end
  endtask

  task automatic test_slow_ticks();
    logic exp_tick;
    logic exp_sq;
    exp_sq = 1'b0;
    release_reset(2'b00);
    for (int e = 1; e <= 31; e++) begin
      next_edge();
      exp_tick = (e % 10 == 0);
      if (exp_tick) exp_sq = ~exp_sq;
      vectors++; if (bus.tick !== exp_tick) begin miscompares++; $display("FAIL slow_tick edge %0d got %b want %b", e, bus.tick, exp_tick); end
      vectors++; if (bus.sq !== exp_sq) begin miscompares++; $display("FAIL slow_sq edge %0d got %b want %b", e, bus.sq, exp_sq); end
      vectors++; if (bus.rate_sel !== 1'b0) begin miscompares++; $display("FAIL slow_rate edge %0d got %b want 0", e, bus.rate_sel); end
    end
  endtask

  task automatic test_debounce_clean();
    logic [1:0] exp_db;
    logic [1:0] exp_rise;
    release_reset(2'b00);
    for (int e = 1; e <= 12; e++) begin
      next_edge();
      exp_db   = {1'b0, (e >= 8)};
      exp_rise = {1'b0, (e == 8)};
      vectors++; if (bus.sw_db !== exp_db) begin miscompares++; $display("FAIL clean_sw_db edge %0d got %b want %b", e, bus.sw_db, exp_db); end
      vectors++; if (bus.sw_rise !== exp_rise) begin miscompares++; $display("FAIL clean_sw_rise edge %0d got %b want %b", e, bus.sw_rise, exp_rise); end
      if (e == 2) bus.sw_in = 2'b01;
    end
  endtask

  task automatic test_debounce_glitch();
    release_reset(2'b00);
    for (int e = 1; e <= 14; e++) begin
      next_edge();
      vectors++; if (bus.sw_db !== 2'b00) begin miscompares++; $display("FAIL glitch_sw_db edge %0d got %b want 00", e, bus.sw_db); end
      vectors++; if (bus.sw_rise !== 2'b00) begin miscompares++; $display("FAIL glitch_sw_rise edge %0d got %b want 00", e, bus.sw_rise); end
      if (e == 2) bus.sw_in = 2'b01;
      if (e == 5) bus.sw_in = 2'b00;
    end
  endtask

  task automatic test_rate_change();
    logic exp_tick;
    logic exp_rate;
    logic exp_sq;
    exp_sq = 1'b0;
    release_reset(2'b00);
    for (int e = 1; e <= 26; e++) begin
      next_edge();
      exp_tick = (e == 10) || (e > 10 && (e - 10) % 5 == 0);
      exp_rate = (e >= 10);
      if (exp_tick) exp_sq = ~exp_sq;
      vectors++; if (bus.tick !== exp_tick) begin miscompares++; $display("FAIL rate_tick edge %0d got %b want %b", e, bus.tick, exp_tick); end
      vectors++; if (bus.rate_sel !== exp_rate) begin miscompares++; $display("FAIL rate_sel edge %0d got %b want %b", e, bus.rate_sel, exp_rate); end
      vectors++; if (bus.sq !== exp_sq) begin miscompares++; $display("FAIL rate_sq edge %0d got %b want %b", e, bus.sq, exp_sq); end
      if (e == 3) bus.sw_in = 2'b10;
    end
  endtask

  task automatic test_rate_same_edge();
    logic exp_tick;
    logic exp_rate;
    logic exp_db1;
    release_reset(2'b00);
    for (int e = 1; e <= 31; e++) begin
      next_edge();
      exp_db1  = (e >= 10);
      exp_tick = (e == 10) || (e >= 20 && (e - 20) % 5 == 0);
      exp_rate = (e >= 20);
      vectors++; if (bus.sw_db[1] !== exp_db1) begin miscompares++; $display("FAIL same_edge_db1 edge %0d got %b want %b", e, bus.sw_db[1], exp_db1); end
      vectors++; if (bus.tick !== exp_tick) begin miscompares++; $display("FAIL same_edge_tick edge %0d got %b want %b", e, bus.tick, exp_tick); end
      vectors++; if (bus.rate_sel !== exp_rate) begin miscompares++; $display("FAIL same_edge_rate edge %0d got %b want %b", e, bus.rate_sel, exp_rate); end
      if (e == 4) bus.sw_in = 2'b10;
    end
  endtask

  // sw_db[1] drops at wrap edge 20 and returns at edge 24, never present at a wrap.
  task automatic test_toggle_within_fast();
    logic exp_tick;
    logic exp_rate;
    logic exp_db1;
    logic exp_rise1;
    release_reset(2'b10);
    for (int e = 1; e <= 36; e++) begin
      next_edge();
      exp_db1   = (e >= 6) && !(e >= 20 && e <= 23);
      exp_rise1 = (e == 6) || (e == 24);
      exp_tick  = (e >= 10) && (e % 5 == 0);
      exp_rate  = (e >= 10);
      vectors++; if (bus.sw_db[1] !== exp_db1) begin miscompares++; $display("FAIL toggle_db1 edge %0d got %b want %b", e, bus.sw_db[1], exp_db1); end
      vectors++; if (bus.sw_rise[1] !== exp_rise1) begin miscompares++; $display("FAIL toggle_rise1 edge %0d got %b want %b", e, bus.sw_rise[1], exp_rise1); end
      vectors++; if (bus.tick !== exp_tick) begin miscompares++; $display("FAIL toggle_tick edge %0d got %b want %b", e, bus.tick, exp_tick); end
      vectors++; if (bus.rate_sel !== exp_rate) begin miscompares++; $display("FAIL toggle_rate edge %0d got %b want %b", e, bus.rate_sel, exp_rate); end
      if (e == 14) bus.sw_in = 2'b00;
      if (e == 18) bus.sw_in = 2'b10;
    end
  endtask

  task automatic test_reset_mid();
    logic exp_tick;
    release_reset(2'b11);
    for (int e = 1; e <= 10; e++) begin
      next_edge();
      if (e == 7) bus.sw_in = 2'b01;
    end
    vectors++; if (bus.sw_db !== 2'b11) begin miscompares++; $display("FAIL pre_reset_sw_db got %b want 11", bus.sw_db); end
    vectors++; if (bus.tick !== 1'b1) begin miscompares++; $display("FAIL pre_reset_tick got %b want 1", bus.tick); end
    vectors++; if (bus.sq !== 1'b1) begin miscompares++; $display("FAIL pre_reset_sq got %b want 1", bus.sq); end
    vectors++; if (bus.rate_sel !== 1'b1) begin miscompares++; $display("FAIL pre_reset_rate got %b want 1", bus.rate_sel); end
    #3;
    rs = 1'b1;
    #1;
    vectors++; if (bus.sw_db !== 2'b00) begin miscompares++; $display("FAIL async_reset_sw_db got %b want 00", bus.sw_db); end
    vectors++; if (bus.tick !== 1'b0) begin miscompares++; $display("FAIL async_reset_tick got %b want 0", bus.tick); end
    vectors++; if (bus.sq !== 1'b0) begin miscompares++; $display("FAIL async_reset_sq got %b want 0", bus.sq); end
    vectors++; if (bus.rate_sel !== 1'b0) begin miscompares++; $display("FAIL async_reset_rate got %b want 0", bus.rate_sel); end
    release_reset(2'b00);
    for (int e = 1; e <= 12; e++) begin
      next_edge();
      exp_tick = (e == 10);
      vectors++; if (bus.tick !== exp_tick) begin miscompares++; $display("FAIL post_reset_tick edge %0d got %b want %b", e, bus.tick, exp_tick); end
      vectors++; if (bus.rate_sel !== 1'b0) begin miscompares++; $display("FAIL post_reset_rate edge %0d got %b want 0", e, bus.rate_sel); end
      vectors++; if (bus.sw_db !== 2'b00) begin miscompares++; $display("FAIL post_reset_sw_db edge %0d got %b want 00", e, bus.sw_db); end
    end
  endtask

  initial begin
    bus.sw_in = 2'b00;
    test_reset();
    test_slow_ticks();
    test_debounce_clean();
    test_debounce_glitch();
    test_rate_change();
    test_rate_same_edge();
    test_toggle_within_fast();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
